// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector-side benches.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int PAT_W_DEFAULT = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first; load has priority over shift.
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pin,
  output logic         sout
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= pin;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign sout = sr[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated
// max(repeat_n,1) times with GAP_LEN idle cycles between repetitions.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W   = PAT_W_DEFAULT,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(PAT_W - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] REP_ONE    = CNT_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             accept;
  logic             bit_last;
  logic             more_reps;
  logic             gap_done;
  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_pin;

  // Handshake: a request transfers on a rising edge where pat_valid and
  // pat_ready are both high; pat_ready is high only in IDLE and out of reset,
  // and pat_valid seen at any other time is dropped, never queued.
  assign pat_ready = (state == ST_IDLE) && !reset;
  assign accept    = pat_valid && pat_ready;
  assign fsm_state = state;

  assign bit_last  = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign more_reps = (rep_cnt != REP_ONE);
  assign gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);

  // With a gap, the reload waits until the gap ends so the drained (all-zero)
  // register holds dout low during the gap without an output gate.
  assign sr_load  = accept || (bit_last && more_reps && (GAP_LEN == 0)) || gap_done;
  assign sr_shift = (state == ST_SHIFT);
  assign sr_pin   = accept ? pat : pat_q;

  piso_shift_reg #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .pin   (sr_pin),
    .sout  (dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_last <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pat_q      <= pat;
            rep_cnt    <= (repeat_n == '0) ? REP_ONE : repeat_n;
            bit_cnt    <= '0;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          // Registered flag lands on the final bit of the final repetition.
          if ((bit_cnt == BIT_PENULT) && !more_reps) begin
            dout_last <= 1'b1;
          end
          if (bit_last) begin
            bit_cnt <= '0;
            if (more_reps) begin
              rep_cnt <= rep_cnt - REP_ONE;
              if (GAP_LEN > 0) begin
                gap_cnt    <= '0;
                dout_valid <= 1'b0;
                state      <= ST_GAP;
              end
            end else begin
              dout_valid <= 1'b0;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_done) begin
            dout_valid <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: two instances (GAP_LEN 0 and 2) checked cycle by cycle
// against an expected output trace built from the request.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  logic       clk;
  logic       reset;
  logic       pv        [2];
  logic [3:0] pat_in    [2];
  logic [3:0] rn        [2];
  logic       ready     [2];
  logic       dout      [2];
  logic       dvalid    [2];
  logic       dlast     [2];
  logic       busy      [2];
  state_t     st        [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Each entry: {dout_valid, dout, dout_last} for one cycle of a request.
  logic [2:0] exp_q[$];

  pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_LEN(0)) u_dut0 (
    .clk(clk), .reset(reset), .pat_valid(pv[0]), .pat_ready(ready[0]),
    .pat(pat_in[0]), .repeat_n(rn[0]), .dout(dout[0]), .dout_valid(dvalid[0]),
    .dout_last(dlast[0]), .busy(busy[0]), .fsm_state(st[0])
  );

  pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_LEN(2)) u_dut2 (
    .clk(clk), .reset(reset), .pat_valid(pv[1]), .pat_ready(ready[1]),
    .pat(pat_in[1]), .repeat_n(rn[1]), .dout(dout[1]), .dout_valid(dvalid[1]),
    .dout_last(dlast[1]), .busy(busy[1]), .fsm_state(st[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Expected trace straight from the stream definition.
  task automatic build_trace(input logic [3:0] p, input int n, input int gap);
    int reps;
    reps = (n == 0) ? 1 : n;
    exp_q.delete();
    for (int r = 0; r < reps; r++) begin
      for (int b = 3; b >= 0; b--)
        exp_q.push_back({1'b1, p[b], (r == reps - 1) && (b == 0)});
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(3'b000);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_valid"}, dvalid[d], 1'b0);
    check({tag, "_last"},  dlast[d],  1'b0);
    check({tag, "_busy"},  busy[d],   1'b0);
    check({tag, "_ready"}, ready[d],  1'b1);
    check({tag, "_state"}, 32'(st[d]), 32'(ST_IDLE));
  endtask

  // Called at a negedge with the instance idle; returns at a negedge, idle.
  task automatic send(input int d, input logic [3:0] p, input logic [3:0] n, input bit noise);
    logic [2:0] e;
    build_trace(p, int'(n), gap_of(d));
    check("pre_ready", ready[d], 1'b1);
    pv[d] = 1'b1;
    pat_in[d] = p;
    rn[d] = n;
    @(negedge clk);
    pv[d] = noise;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid", dvalid[d], e[2]);
      check("dout",  dout[d] & dvalid[d] | dout[d] & !e[2], e[1]);
      check("last",  dlast[d], e[0]);
      check("busy",  busy[d],  1'b1);
      check("ready_busy", ready[d], 1'b0);
      pat_in[d] = 4'($urandom_range(0, 15));
      rn[d] = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    pv[d] = 1'b0;
    check_idle(d, "end");
    @(negedge clk);
    check_idle(d, "end2");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0;
      pat_in[d] = '0;
      rn[d] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", dvalid[d], 1'b0);
      check("rst_dout",  dout[d],   1'b0);
      check("rst_last",  dlast[d],  1'b0);
      check("rst_busy",  busy[d],   1'b0);
      check("rst_ready", ready[d],  1'b0);
      check("rst_state", 32'(st[d]), 32'(ST_IDLE));
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the stream definition.
    send(0, 4'b1010, 4'd1, 1'b0);
    send(1, 4'b1010, 4'd3, 1'b0);
    send(0, 4'b0110, 4'd0, 1'b0);
    send(1, 4'b0110, 4'd0, 1'b0);
    send(0, 4'b1100, 4'd1, 1'b1);
    send(0, 4'b1010, 4'd2, 1'b0);
    send(1, 4'b1001, 4'd15, 1'b1);

    // Reset in cycle 2 of a 1010 transmission.
    pv[0] = 1'b1;
    pat_in[0] = 4'b1010;
    rn[0] = 4'd1;
    @(negedge clk);
    pv[0] = 1'b0;
    check("abort_c1_dout", dout[0], 1'b1);
    check("abort_c1_valid", dvalid[0], 1'b1);
    @(negedge clk);
    check("abort_c2_dout", dout[0], 1'b0);
    check("abort_c2_valid", dvalid[0], 1'b1);
    reset = 1'b1;
    #1;
    check("abort_ready_rst", ready[0], 1'b0);
    @(negedge clk);
    check("abort_valid", dvalid[0], 1'b0);
    check("abort_dout",  dout[0],   1'b0);
    check("abort_busy",  busy[0],   1'b0);
    check("abort_last",  dlast[0],  1'b0);
    check("abort_state", 32'(st[0]), 32'(ST_IDLE));
    check("abort_ready_hold", ready[0], 1'b0);
    reset = 1'b0;
    #1;
    check("abort_ready_rel", ready[0], 1'b1);
    @(negedge clk);
    send(0, 4'b1110, 4'd1, 1'b0);

    // Randomized requests on both instances.
    for (int i = 0; i < 24; i++) begin
      send(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
